// File: rtl/ones_counter_stream.sv
// Streaming ones counter: per-beat popcount plus a per-frame total with a stalling handoff.
// Build option: define ONES_COUNTER_STREAM_SATURATE_EN to clamp acc/total instead of wrapping.
module ones_counter_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  input  logic                          din_last,
  output logic                          din_ready,
  output logic [$clog2(DATA_WIDTH):0]   beat_count,
  output logic                          beat_valid,
  output logic [ACC_WIDTH-1:0]          total,
  output logic                          total_valid,
  input  logic                          total_ready,
  output logic                          overflow
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   frame_ovf;
  logic                   accept;
  logic [CW-1:0]          din_ones;
  logic [ACC_WIDTH:0]     sum;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   sum_fit;

  function automatic logic [CW-1:0] popcount(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      n = n + CW'(d[i]);
    end
    return n;
  endfunction

  assign din_ones = popcount(din);
  assign sum      = {1'b0, acc} + (ACC_WIDTH+1)'(din_ones);
  assign carry    = sum[ACC_WIDTH];

  // A carry out of the accumulator either wraps naturally or pins at all-ones.
`ifdef ONES_COUNTER_STREAM_SATURATE_EN
  assign sum_fit = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign sum_fit = sum[ACC_WIDTH-1:0];
`endif

  assign total_valid = (state == HOLD);

  // In HOLD a beat can only enter while the consumer drains the held total.
  always_comb begin
    din_ready  = 1'b1;
    state_next = state;
    case (state)
      ACCUM: begin
        din_ready = 1'b1;
        if (din_valid && din_last) begin
          state_next = HOLD;
        end else begin
          state_next = ACCUM;
        end
      end
      HOLD: begin
        din_ready = total_ready;
        if (total_ready) begin
          if (din_valid && din_last) begin
            state_next = HOLD;
          end else begin
            state_next = ACCUM;
          end
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        din_ready  = 1'b1;
        state_next = ACCUM;
      end
    endcase
    accept = din_valid && din_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // acc is already zero after a last beat, so a frame started from HOLD needs no special case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      frame_ovf  <= 1'b0;
      total      <= '0;
      overflow   <= 1'b0;
      beat_count <= '0;
      beat_valid <= 1'b0;
    end else begin
      beat_valid <= accept;
      if (accept) begin
        beat_count <= din_ones;
        if (din_last) begin
          total     <= sum_fit;
          overflow  <= frame_ovf | carry;
          acc       <= '0;
          frame_ovf <= 1'b0;
        end else begin
          acc       <= sum_fit;
          frame_ovf <= frame_ovf | carry;
        end
      end else begin
        beat_count <= beat_count;
      end
    end
  end

endmodule

// File: tb/tb_ones_counter_stream.sv
// Directed bench for ones_counter_stream: a 16-bit and a 4-bit accumulator instance share stimulus.
module tb_ones_counter_stream;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       total_ready;

  logic        din_ready,   din_ready_n;
  logic [3:0]  beat_count,  beat_count_n;
  logic        beat_valid,  beat_valid_n;
  logic [15:0] total;
  logic [3:0]  total_n;
  logic        total_valid, total_valid_n;
  logic        overflow,    overflow_n;

  int n_checks = 0;
  int n_fail   = 0;

  ones_counter_stream #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut_w (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .beat_count(beat_count), .beat_valid(beat_valid),
    .total(total), .total_valid(total_valid), .total_ready(total_ready), .overflow(overflow)
  );

  ones_counter_stream #(.DATA_WIDTH(8), .ACC_WIDTH(4)) dut_n (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready_n), .beat_count(beat_count_n), .beat_valid(beat_valid_n),
    .total(total_n), .total_valid(total_valid_n), .total_ready(total_ready), .overflow(overflow_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame total as an unbounded sum reduced to the accumulator width.
  function automatic int fit(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef ONES_COUNTER_STREAM_SATURATE_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  // Reference model
  logic       m_hold = 1'b0;
  int         m_sum  = 0;
  int         m_bc   = 0;
  logic       m_bv   = 1'b0;
  int         m_tw   = 0;
  logic       m_ow   = 1'b0;
  int         m_tn   = 0;
  logic       m_on   = 1'b0;
  int         m_pc;
  logic       m_accept;
  logic       m_ready;

  assign m_pc     = $countones(din);
  assign m_ready  = !m_hold || total_ready;
  assign m_accept = din_valid && m_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 1'b0;
      m_sum  <= 0;
      m_bc   <= 0;
      m_bv   <= 1'b0;
      m_tw   <= 0;
      m_ow   <= 1'b0;
      m_tn   <= 0;
      m_on   <= 1'b0;
    end else begin
      m_bv <= m_accept;
      if (m_accept) begin
        m_bc <= m_pc;
        if (din_last) begin
          m_sum <= 0;
          m_tw  <= fit(m_sum + m_pc, 16);
          m_ow  <= (m_sum + m_pc) > 65535;
          m_tn  <= fit(m_sum + m_pc, 4);
          m_on  <= (m_sum + m_pc) > 15;
        end else begin
          m_sum <= m_sum + m_pc;
        end
      end
      m_hold <= (m_accept && din_last) || (m_hold && !total_ready);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("din_ready",     int'(din_ready),     int'(m_ready));
    check("din_ready_n",   int'(din_ready_n),   int'(m_ready));
    check("beat_valid",    int'(beat_valid),    int'(m_bv));
    check("beat_count",    int'(beat_count),    m_bc);
    check("beat_count_n",  int'(beat_count_n),  m_bc);
    check("total_valid",   int'(total_valid),   int'(m_hold));
    check("total_valid_n", int'(total_valid_n), int'(m_hold));
    if (m_hold) begin
      check("total",      int'(total),      m_tw);
      check("overflow",   int'(overflow),   int'(m_ow));
      check("total_n",    int'(total_n),    m_tn);
      check("overflow_n", int'(overflow_n), int'(m_on));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    din       = d;
    din_valid = 1'b1;
    din_last  = last;
    step();
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din_last  = 1'b0;
    step();
  endtask

  initial begin
    logic [8:0] mask;
    rst         = 1'b1;
    din         = 8'h00;
    din_valid   = 1'b0;
    din_last    = 1'b0;
    total_ready = 1'b1;
    step();
    check("rst_total_valid", int'(total_valid), 0);
    check("rst_beat_valid",  int'(beat_valid),  0);
    check("rst_beat_count",  int'(beat_count),  0);
    check("rst_total",       int'(total),       0);
    check("rst_overflow",    int'(overflow),    0);
    check("rst_din_ready",   int'(din_ready),   1);
    rst = 1'b0;
    step();

    // Ramp 00..FF: beat counts 0..8, frame total 36.
    for (int i = 0; i <= 8; i++) begin
      mask = (9'd1 << i) - 9'd1;
      send(mask[7:0], (i == 8));
      check("ramp_beat_count", int'(beat_count), i);
      check("ramp_beat_valid", int'(beat_valid), 1);
    end
    check("ramp_total",       int'(total),       36);
    check("ramp_overflow",    int'(overflow),    0);
    check("ramp_total_valid", int'(total_valid), 1);
`ifdef ONES_COUNTER_STREAM_SATURATE_EN
    check("ramp_total_n", int'(total_n), 15);
`else
    check("ramp_total_n", int'(total_n), 4);
`endif
    check("ramp_overflow_n", int'(overflow_n), 1);
    idle();
    check("ramp_total_valid_pulse", int'(total_valid), 0);
    check("idle_beat_valid",        int'(beat_valid),  0);

    // Single-beat frame A5 held while the consumer stalls; a pending beat must wait.
    total_ready = 1'b0;
    send(8'hA5, 1'b1);
    din      = 8'hFF;
    din_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_din_ready",   int'(din_ready),   0);
      check("hold_total",       int'(total),       4);
      check("hold_total_valid", int'(total_valid), 1);
      check("hold_beat_valid",  int'(beat_valid),  0);
    end
    total_ready = 1'b1;
    step();
    check("drain_total_valid", int'(total_valid), 0);
    check("drain_beat_count",  int'(beat_count),  8);
    send(8'h01, 1'b1);
    check("drain_next_total", int'(total), 9);
    idle();

    // Back-to-back single-beat frames.
    send(8'hFF, 1'b1);
    check("b2b_total0", int'(total), 8);
    check("b2b_tv0",    int'(total_valid), 1);
    send(8'h0F, 1'b1);
    check("b2b_total1", int'(total), 4);
    check("b2b_tv1",    int'(total_valid), 1);
    send(8'h01, 1'b1);
    check("b2b_total2", int'(total), 1);
    check("b2b_tv2",    int'(total_valid), 1);
    idle();
    check("b2b_tv_end", int'(total_valid), 0);

    // Narrow accumulator overflow, then a clean frame.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
`ifdef ONES_COUNTER_STREAM_SATURATE_EN
    check("ovf_total_n", int'(total_n), 15);
`else
    check("ovf_total_n", int'(total_n), 0);
`endif
    check("ovf_overflow_n", int'(overflow_n), 1);
    check("ovf_total_w",    int'(total),      16);
    check("ovf_overflow_w", int'(overflow),   0);
    send(8'h01, 1'b1);
    check("post_ovf_total_n",    int'(total_n),    1);
    check("post_ovf_overflow_n", int'(overflow_n), 0);
    idle();

    // Reset mid-frame, with an unqualified din_last cycle before it.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    din       = 8'hFF;
    din_valid = 1'b0;
    din_last  = 1'b1;
    step();
    check("unqual_last_tv", int'(total_valid), 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_beat_count", int'(beat_count),  0);
    check("mid_rst_beat_valid", int'(beat_valid),  0);
    check("mid_rst_total",      int'(total),       0);
    check("mid_rst_tv",         int'(total_valid), 0);
    check("mid_rst_overflow",   int'(overflow),    0);
    check("mid_rst_din_ready",  int'(din_ready),   1);
    check("mid_rst_total_n",    int'(total_n),     0);
    step();
    rst = 1'b0;
    check("post_rst_din_ready", int'(din_ready), 1);
    send(8'h03, 1'b1);
    check("post_rst_total",    int'(total),    2);
    check("post_rst_total_n",  int'(total_n),  2);
    check("post_rst_overflow", int'(overflow), 0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ones_counter_stream.md
ONES_COUNTER_STREAM -- requirements
Module: ones_counter_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, input beat width in bits (>= 1).
REQ-002 SHALL have parameter ACC_WIDTH, default 16, frame-total width (>= $clog2(DATA_WIDTH)+1).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port din  input  DATA_WIDTH  data beat.
REQ-006 SHALL have port din_valid  input  1  beat present.
REQ-007 SHALL have port din_last  input  1  beat is last of frame; qualified by din_valid.
REQ-008 SHALL have port din_ready  output  1  block can accept a beat.
REQ-009 SHALL have port beat_count  output  $clog2(DATA_WIDTH)+1  ones in most recently accepted beat.
REQ-010 SHALL have port beat_valid  output  1  one-cycle pulse qualifying beat_count.
REQ-011 SHALL have port total  output  ACC_WIDTH  ones in the completed frame.
REQ-012 SHALL have port total_valid  output  1  total/overflow presented.
REQ-013 SHALL have port total_ready  input  1  consumer takes total.
REQ-014 SHALL have port overflow  output  1  frame sum exceeded 2^ACC_WIDTH-1; qualified by total_valid.

Function
REQ-015 SHALL accept a beat when din_valid && din_ready at a rising edge ("accept").
REQ-016 SHALL drive beat_count = popcount(din of accepted beat) and pulse beat_valid the cycle after accept (latency 1), independent of total_ready.
REQ-017 SHALL run a 2-state FSM: ACCUM (total_valid=0) and HOLD (total_valid=1).
REQ-018 SHALL drive din_ready = 1 in ACCUM and din_ready = total_ready in HOLD (combinational).
REQ-019 SHALL, on accept of a non-last beat, add its popcount into the running accumulator (acc).
REQ-020 SHALL, on accept of a last beat, load total = acc + popcount(din), load overflow, clear acc to 0, and enter HOLD next cycle; a single-beat frame is legal.
REQ-021 SHALL hold total and overflow stable while total_valid && !total_ready.
REQ-022 SHALL, in HOLD with total_ready=1 and no accept, return to ACCUM.
REQ-023 SHALL, in HOLD with total_ready=1 and an accepted non-last beat, drain the total, start the new frame acc = popcount(din), and go to ACCUM.
REQ-024 SHALL, in HOLD with total_ready=1 and an accepted last beat, stay in HOLD with the new single-beat total (back-to-back totals, no bubble).
REQ-025 SHALL set the frame overflow flag when any addition within the frame carries out of ACC_WIDTH; the flag is sticky until the frame total is loaded, then cleared for the next frame.
REQ-026 SHALL ignore din_last when din_valid=0, and ignore din entirely when not accepted.

Reset
REQ-027 SHALL, on rst assertion, asynchronously force state ACCUM, acc=0, frame overflow flag=0, total=0, overflow=0, beat_count=0, beat_valid=0, total_valid=0.
REQ-028 SHALL discard a partially accumulated frame on reset; first accept after rst deassertion starts a new frame.
REQ-029 SHALL drive din_ready=1 during and immediately after reset.

Configuration
REQ-030 SHALL, with macro ONES_COUNTER_STREAM_SATURATE_EN defined, clamp acc and total at 2^ACC_WIDTH-1 on overflow (overflow still asserted).
REQ-031 SHALL, without ONES_COUNTER_STREAM_SATURATE_EN, wrap acc and total modulo 2^ACC_WIDTH (overflow still asserted).

Verification (DATA_WIDTH=8, ACC_WIDTH=16 unless stated)
REQ-032 SHALL cover: reset, then beats 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF (last) with total_ready=1 -> beat_count 0..8 one cycle after each accept, total=36, overflow=0, total_valid one cycle.
REQ-033 SHALL cover: single-beat frame 8'hA5 last with total_ready=0 for 5 cycles -> total=4 held, din_ready=0 throughout, released on total_ready=1.
REQ-034 SHALL cover: back-to-back last beats 8'hFF, 8'h0F, 8'h01 with total_ready=1 -> totals 8, 4, 1 on consecutive cycles, total_valid continuously high.
REQ-035 SHALL cover: ACC_WIDTH=4, frame 8'hFF, 8'hFF (last) -> overflow=1 and total=0 (wrap) or total=15 (saturate build); following frame 8'h01 last -> total=1, overflow=0.
REQ-036 SHALL cover: rst asserted mid-frame after beats 8'hFF, 8'hFF -> all outputs zero immediately; next frame 8'h03 last -> total=2.
